// File: rtl/sram_frame_reader.sv
// Reads a rows x cols frame from an asynchronous 16-bit SRAM and emits it as a typed beat stream.
// Control beats (FS/RS/RE/FE) are one state each; pixel beats fire on the last cycle of each read window.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FSTART
`define DTYPE_FSTART 4'd1
`define DTYPE_RSTART 4'd2
`define DTYPE_PIXEL  4'd3
`define DTYPE_REND   4'd4
`define DTYPE_FEND   4'd5
`endif

module sram_frame_reader #(
  parameter int ADDR_WIDTH = 19,
  parameter int DIM_WIDTH  = 12,
  parameter int READ_WAIT  = 1
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic                    enable,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [DIM_WIDTH-1:0]    num_cols,
  input  logic [DIM_WIDTH-1:0]    num_rows,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic                    ceb,
  output logic                    oeb,
  output logic                    web,
  inout  wire  [15:0]             ram_databus,
  output logic                    dvo,
  output logic [`DTYPE_WIDTH-1:0] dtypeo,
  output logic [15:0]             datao,
  output logic [2:0]              state_dbg
);

  typedef enum logic [2:0] {IDLE, FSTART, RSTART, READ, REND, FEND} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(READ_WAIT);

  state_t                state, next_state;
  logic [DIM_WIDTH-1:0]  cols_q, rows_q;
  logic [DIM_WIDTH-1:0]  col_cnt, row_cnt;
  logic [3:0]            wait_cnt;
  logic                  last_wait, last_col, last_row, pix;

  assign ram_databus = 16'bz;
  assign web         = 1'b1;
  assign state_dbg   = state;

  assign last_wait = (wait_cnt == WAIT_LAST);
  assign last_col  = (col_cnt == cols_q - DIM_WIDTH'(1));
  assign last_row  = (row_cnt == rows_q - DIM_WIDTH'(1));
  // A pixel is only delivered if enable is still high on its sampling edge.
  assign pix       = (state == READ) && last_wait && enable;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start && enable) next_state = FSTART;
      FSTART:  if (!enable || rows_q == '0 || cols_q == '0) next_state = FEND;
               else next_state = RSTART;
      RSTART:  next_state = enable ? READ : FEND;
      READ:    if (!enable) next_state = FEND;
               else if (last_wait && last_col) next_state = REND;
      REND:    if (!enable || last_row) next_state = FEND;
               else next_state = RSTART;
      FEND:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      addr     <= '0;
      cols_q   <= '0;
      rows_q   <= '0;
      col_cnt  <= '0;
      row_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start && enable) begin
          addr     <= base_addr;
          cols_q   <= num_cols;
          rows_q   <= num_rows;
          col_cnt  <= '0;
          row_cnt  <= '0;
          wait_cnt <= '0;
        end
        RSTART: begin
          col_cnt  <= '0;
          wait_cnt <= '0;
        end
        // Addresses run contiguously across rows and wrap naturally at the top.
        READ: if (enable) begin
          if (last_wait) begin
            wait_cnt <= '0;
            addr     <= addr + ADDR_WIDTH'(1);
            col_cnt  <= col_cnt + DIM_WIDTH'(1);
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        REND:    row_cnt <= row_cnt + DIM_WIDTH'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    busy   = (state != IDLE);
    ceb    = (state != READ);
    oeb    = (state != READ);
    dvo    = 1'b0;
    dtypeo = '0;
    datao  = '0;
    case (state)
      FSTART: begin dvo = 1'b1; dtypeo = `DTYPE_FSTART; end
      RSTART: begin dvo = 1'b1; dtypeo = `DTYPE_RSTART; end
      REND:   begin dvo = 1'b1; dtypeo = `DTYPE_REND;   end
      FEND:   begin dvo = 1'b1; dtypeo = `DTYPE_FEND;   end
      READ: if (pix) begin
        dvo    = 1'b1;
        dtypeo = `DTYPE_PIXEL;
        datao  = ram_databus;
      end
      default: ;
    endcase
  end

endmodule
